// File: rtl/ysyx_23060077_riscv_ex_mdu.sv
// Iterative RV64M multiply/divide unit for the EX stage: radix-2 shift-add multiply,
// restoring divide, one result bit per cycle, valid/ready on both sides with flush.
module ysyx_23060077_riscv_ex_mdu #(
  parameter int DATA_WIDTH = 64,
  parameter int OPT_WIDTH  = 3,
  parameter int CNT_WIDTH  = 7
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [OPT_WIDTH-1:0]  mdu_opt,
  input  logic                  mdu_word,
  input  logic [DATA_WIDTH-1:0] mdu_a_data,
  input  logic [DATA_WIDTH-1:0] mdu_b_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] mdu_out_data
);

  localparam int DW = DATA_WIDTH;
  localparam logic signed [31:0] MIN_W = 32'sh8000_0000;

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
  state_t state_q, state_d;

  function automatic logic [DW-1:0] sext_w(input logic [DW-1:0] v);
    logic signed [31:0] lo;
    lo = v[31:0];
    return DW'(lo);
  endfunction

  function automatic logic [DW-1:0] zext_w(input logic [DW-1:0] v);
    return DW'(v[31:0]);
  endfunction

  function automatic logic [DW-1:0] fit_w(input logic [DW-1:0] v, input logic word);
    return word ? sext_w(v) : v;
  endfunction

  logic              accept, is_div, a_sgn, b_sgn, a_neg, b_neg;
  logic              div_zero, div_ovf, fast, last_iter;
  logic [DW-1:0]     a_ext, b_ext, a_abs, b_abs, min_n, fast_res;

  logic [OPT_WIDTH-1:0] opt_q;
  logic              word_q, neg_q, rneg_q;
  logic [2*DW-1:0]   acc_q, mcand_q, sum_acc, prod;
  logic [DW-1:0]     mplier_q, rem_q, quo_q, dvs_q;
  logic [DW:0]       shifted, sub;
  logic [DW-1:0]     rem_nxt, quo_nxt, quo_fin, rem_fin, res, res_fin;
  logic [CNT_WIDTH-1:0] cnt_q;

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign accept    = in_valid & in_ready & ~flush;

  // Operand conditioning and the single-cycle divide corner cases
  always_comb begin
    is_div   = mdu_opt[2];
    a_sgn    = is_div ? ~mdu_opt[0] : (mdu_opt[1:0] != 2'b11);
    b_sgn    = is_div ? ~mdu_opt[0] : ~mdu_opt[1];
    a_ext    = mdu_word ? (a_sgn ? sext_w(mdu_a_data) : zext_w(mdu_a_data)) : mdu_a_data;
    b_ext    = mdu_word ? (b_sgn ? sext_w(mdu_b_data) : zext_w(mdu_b_data)) : mdu_b_data;
    a_neg    = a_sgn & a_ext[DW-1];
    b_neg    = b_sgn & b_ext[DW-1];
    a_abs    = a_neg ? -a_ext : a_ext;
    b_abs    = b_neg ? -b_ext : b_ext;
    min_n    = mdu_word ? DW'(MIN_W) : {1'b1, {(DW-1){1'b0}}};
    div_zero = is_div & (b_ext == '0);
    div_ovf  = is_div & ~mdu_opt[0] & (a_ext == min_n) & (b_ext == '1);
    fast     = div_zero | div_ovf;
    fast_res = fit_w(div_zero ? (mdu_opt[1] ? a_ext : '1) : (mdu_opt[1] ? '0 : a_ext), mdu_word);
  end

  // One iteration step plus sign fix-up and result select for the final step
  always_comb begin
    sum_acc   = mplier_q[0] ? acc_q + mcand_q : acc_q;
    shifted   = {rem_q, quo_q[DW-1]};
    sub       = shifted - {1'b0, dvs_q};
    rem_nxt   = sub[DW] ? shifted[DW-1:0] : sub[DW-1:0];
    quo_nxt   = {quo_q[DW-2:0], ~sub[DW]};
    prod      = neg_q ? -sum_acc : sum_acc;
    quo_fin   = neg_q ? -quo_nxt : quo_nxt;
    rem_fin   = rneg_q ? -rem_nxt : rem_nxt;
    last_iter = (cnt_q == CNT_WIDTH'(word_q ? 31 : DW - 1));
    if (opt_q[2])
      res = opt_q[1] ? rem_fin : quo_fin;
    else if (opt_q[1:0] == 2'b00)
      res = prod[DW-1:0];
    else
      res = word_q ? DW'(prod[63:32]) : prod[2*DW-1:DW];
    res_fin = fit_w(res, word_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept)    state_d = fast ? DONE : CALC;
      CALC:    if (last_iter) state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default:                state_d = IDLE;
    endcase
    if (flush) state_d = IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q        <= '0;
      mdu_out_data <= '0;
    end else if (accept) begin
      cnt_q <= '0;
      if (fast) mdu_out_data <= fast_res;
    end else if (state_q == CALC && !flush) begin
      cnt_q <= cnt_q + CNT_WIDTH'(1);
      if (last_iter) mdu_out_data <= res_fin;
    end
  end

  // Word-mode dividends are pre-aligned to the top so the same shifter serves both widths
  always_ff @(posedge clk) begin
    if (accept) begin
      opt_q    <= mdu_opt;
      word_q   <= mdu_word;
      neg_q    <= a_neg ^ b_neg;
      rneg_q   <= a_neg;
      acc_q    <= '0;
      mcand_q  <= {{DW{1'b0}}, a_abs};
      mplier_q <= b_abs;
      rem_q    <= '0;
      quo_q    <= (mdu_word && DW > 32) ? a_abs << 32 : a_abs;
      dvs_q    <= b_abs;
    end else if (state_q == CALC) begin
      acc_q    <= sum_acc;
      mcand_q  <= mcand_q << 1;
      mplier_q <= mplier_q >> 1;
      rem_q    <= rem_nxt;
      quo_q    <= quo_nxt;
    end
  end

endmodule

// File: tb/tb_ysyx_23060077_riscv_ex_mdu.sv
// Scoreboard bench for the iterative MDU: directed corner cases, flush, mid-op reset
// and randomized operations checked against a wide-integer arithmetic model.
module tb_ysyx_23060077_riscv_ex_mdu;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [2:0]  mdu_opt = 3'd0;
  logic        mdu_word = 1'b0;
  logic [63:0] mdu_a_data = 64'd0;
  logic [63:0] mdu_b_data = 64'd0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [63:0] mdu_out_data;

  ysyx_23060077_riscv_ex_mdu #(.DATA_WIDTH(64), .OPT_WIDTH(3), .CNT_WIDTH(7)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .mdu_opt(mdu_opt), .mdu_word(mdu_word),
    .mdu_a_data(mdu_a_data), .mdu_b_data(mdu_b_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .mdu_out_data(mdu_out_data)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [63:0] data;
    int          lat;
    int unsigned acc_cyc;
    string       name;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   passed = 0;
  bit   hold_req = 1'b0;
  bit   seen = 1'b0;
  bit   expect_low = 1'b0;
  int   hold = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %h required %h (t=%0t)", name, got, exp, $time);
  endtask

  function automatic logic signed [127:0] ext(input logic [63:0] v, input bit word, input bit s);
    if (word) return s ? {{96{v[31]}}, v[31:0]} : {96'd0, v[31:0]};
    return s ? {{64{v[63]}}, v} : {64'd0, v};
  endfunction

  // Reference: exact wide-integer arithmetic with the RISC-V M-extension rules
  function automatic void model(input logic [2:0] opt, input bit word, input logic [63:0] a,
                                input logic [63:0] b, output logic [63:0] res, output int lat);
    logic signed [127:0] ax, bx, p, q, r, min_n;
    logic [63:0] raw;
    bit a_s, b_s;
    case (opt)
      3'd0, 3'd1: begin a_s = 1; b_s = 1; end  // MUL, MULH
      3'd2:       begin a_s = 1; b_s = 0; end  // MULHSU
      3'd3:       begin a_s = 0; b_s = 0; end  // MULHU
      3'd4, 3'd6: begin a_s = 1; b_s = 1; end  // DIV, REM
      default:    begin a_s = 0; b_s = 0; end  // DIVU, REMU
    endcase
    ax  = ext(a, word, a_s);
    bx  = ext(b, word, b_s);
    lat = word ? 33 : 65;
    if (!opt[2]) begin
      p = ax * bx;
      if (opt == 3'd0) raw = p[63:0];
      else             raw = word ? {32'd0, p[63:32]} : p[127:64];
    end else begin
      min_n = word ? -(128'sd1 <<< 31) : -(128'sd1 <<< 63);
      if (bx == '0) begin
        q = '1; r = ax; lat = 1;
      end else begin
        q = ax / bx; r = ax % bx;
        if (a_s && ax == min_n && bx == '1) lat = 1;
      end
      raw = opt[1] ? r[63:0] : q[63:0];
    end
    res = word ? {{32{raw[31]}}, raw[31:0]} : raw;
  endfunction

  function automatic logic [63:0] pick();
    int s;
    case ($urandom_range(0, 6))
      0, 1: return {$urandom, $urandom};
      2: begin s = int'($urandom_range(0, 40)) - 20; return 64'(s); end
      3: return 64'd0;
      4: return 64'hFFFF_FFFF_FFFF_FFFF;
      5: return 64'h8000_0000_0000_0000;
      default: return {$urandom, 32'h8000_0000};
    endcase
  endfunction

  task automatic issue(input logic [2:0] opt, input bit word, input logic [63:0] a,
                       input logic [63:0] b, input bit track, input string name);
    logic [63:0] res;
    int lat;
    int guard;
    model(opt, word, a, b, res, lat);
    @(negedge clk);
    mdu_opt = opt; mdu_word = word; mdu_a_data = a; mdu_b_data = b; in_valid = 1'b1;
    guard = 0;
    while (!in_ready && guard < 300) begin @(negedge clk); guard++; end
    if (!in_ready) begin
      checks++;
      $display("FAIL %s_accept: in_ready=%b after 300 cycles, required 1", name, in_ready);
      in_valid = 1'b0;
      return;
    end
    @(posedge clk);
    if (track) sb.push_back('{res, lat, cyc, name});
    #1 in_valid = 1'b0;
  endtask

  task automatic drain();
    int g = 0;
    while ((sb.size() != 0 || out_valid) && g < 1000) begin @(negedge clk); g++; end
    if (g >= 1000) begin
      checks++;
      $display("FAIL drain_timeout: %0d results outstanding, required 0", sb.size());
    end
    @(negedge clk);
  endtask

  // Monitor: owns out_ready, checks latency, data, stability and the post-handshake bubble
  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) begin seen = 0; expect_low = 0; out_ready = 1'b0; continue; end
      if (expect_low) begin
        check("bubble_out_valid", 64'(out_valid), 64'd0);
        expect_low = 0;
      end
      if (out_valid) begin
        if (sb.size() == 0) begin
          checks++;
          $display("FAIL unexpected_out_valid: out_valid=1 data %h, required no result", mdu_out_data);
          out_ready = 1'b1;
        end else begin
          if (!seen) begin
            seen = 1;
            check({sb[0].name, "_latency"}, 64'(cyc - sb[0].acc_cyc), 64'(sb[0].lat));
            hold = hold_req ? 10 : int'($urandom_range(0, 2));
            hold_req = 1'b0;
          end
          check({sb[0].name, "_data"}, mdu_out_data, sb[0].data);
          check({sb[0].name, "_in_ready_low"}, 64'(in_ready), 64'd0);
          if (hold > 0) begin
            hold--; out_ready = 1'b0;
          end else begin
            out_ready = 1'b1;
            void'(sb.pop_front());
            seen = 0;
            expect_low = 1;
          end
        end
      end else begin
        out_ready = 1'b0;
      end
    end
  end

  initial begin
    #800000;
    $display("FAIL watchdog: run exceeded time limit, %0d results outstanding", sb.size());
    $fatal(1, "watchdog expired");
  end

  initial begin
    repeat (3) @(negedge clk);
    check("reset_in_ready", 64'(in_ready), 64'd1);
    check("reset_out_valid", 64'(out_valid), 64'd0);
    check("reset_out_data", mdu_out_data, 64'd0);
    rst_n = 1'b1;

    issue(3'd0, 0, 64'd7, -64'd3, 1, "mul_7_m3");
    issue(3'd3, 0, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1, "mulhu_ones");
    issue(3'd2, 0, -64'd1, 64'd2, 1, "mulhsu_m1_2");
    issue(3'd4, 0, -64'd7, 64'd2, 1, "div_m7_2");
    issue(3'd6, 0, -64'd7, 64'd2, 1, "rem_m7_2");
    issue(3'd5, 0, 64'd7, 64'd0, 1, "divu_by0");
    issue(3'd6, 0, 64'd7, 64'd0, 1, "rem_by0");
    issue(3'd4, 0, 64'h8000_0000_0000_0000, -64'd1, 1, "div_ovf");
    issue(3'd6, 0, 64'h8000_0000_0000_0000, -64'd1, 1, "rem_ovf");
    issue(3'd4, 1, 64'h1_8000_0000, -64'd1, 1, "divw_ovf");
    issue(3'd7, 1, 64'hABCD_0000_8000_0005, 64'hFFFF_FFFF_0000_0000, 1, "remuw_by0");
    drain();

    hold_req = 1'b1;
    issue(3'd0, 1, 64'h7FFF_FFFF, 64'd2, 1, "mulw_hold");
    drain();

    issue(3'd4, 0, pick(), 64'd3, 0, "div_flushed");
    repeat (20) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    check("flush_in_ready", 64'(in_ready), 64'd1);
    check("flush_out_valid", 64'(out_valid), 64'd0);
    mdu_opt = 3'd0; mdu_word = 1'b0; in_valid = 1'b1;
    @(negedge clk);
    check("flush_beats_in_valid", 64'(in_ready), 64'd1);
    flush = 1'b0; in_valid = 1'b0;
    repeat (70) @(negedge clk);
    check("flush_no_late_valid", 64'(out_valid), 64'd0);
    issue(3'd4, 0, -64'd7, 64'd2, 1, "div_after_flush");
    drain();

    issue(3'd1, 0, pick(), pick(), 0, "mulh_reset");
    repeat (10) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midreset_in_ready", 64'(in_ready), 64'd1);
    check("midreset_out_valid", 64'(out_valid), 64'd0);
    check("midreset_out_data", mdu_out_data, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    issue(3'd6, 1, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 1, "remw_after_reset");

    for (int i = 0; i < 80; i++) begin
      issue(3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), pick(), pick(), 1,
            $sformatf("rand%0d", i));
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    drain();

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
